dec_4x16_with_fault4: RTL and testbench

// - 4-to-16 one-hot decoder built from two 3-to-8 decoder stages, with a deliberately

---
 rtl/dec_4x16_with_fault4.sv | 49 ++++
 tb/tb_dec_4x16_with_fault4.sv | 131 +++++++++++++
 2 files changed

// File: rtl/dec_4x16_with_fault4.sv
// 4-to-16 one-hot decoder built from two 3-to-8 stages, registered output,
// with a parameterizable stuck-at fault on one output line.

module dec_3x8 (
   input  logic       en,
   input  logic [2:0] sel,
   output logic [7:0] y
);
   assign y = en ? (8'h01 << sel) : 8'h00;
endmodule

module dec_4x16_with_fault4 #(
   parameter int FAULT_EN   = 1,
   parameter int FAULT_LINE = 4,
   parameter int FAULT_VAL  = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        X,
   input  logic        Y,
   input  logic        Z,
   input  logic        W,
   output logic [15:0] D
);
   logic [1:0][7:0] stage_y;
   logic [15:0]     dec;
   logic [15:0]     nxt;

   // X selects which stage is enabled: stage 0 drives D[7:0], stage 1 D[15:8]
   for (genvar g = 0; g < 2; g++) begin : g_stage
      dec_3x8 u_dec (
         .en  (X == g[0]),
         .sel ({Y, Z, W}),
         .y   (stage_y[g])
      );
   end

   assign dec = stage_y;

   always_comb begin
      nxt = dec;
      if (FAULT_EN != 0) nxt[FAULT_LINE] = (FAULT_VAL != 0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) D <= 16'h0000;
      else     D <= nxt;
   end
endmodule

// File: tb/tb_dec_4x16_with_fault4.sv
// Bench for dec_4x16_with_fault4: default, fault-free and stuck-at-1 variants
// driven in parallel and compared against a select-to-one-hot reference.

module tb_dec_4x16_with_fault4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic X = 1'b0, Y = 1'b0, Z = 1'b0, W = 1'b0;
   logic [15:0] d_def, d_ok, d_s1;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dec_4x16_with_fault4 u_def (
      .clk(clk), .rst(rst), .X(X), .Y(Y), .Z(Z), .W(W), .D(d_def));

   dec_4x16_with_fault4 #(.FAULT_EN(0)) u_ok (
      .clk(clk), .rst(rst), .X(X), .Y(Y), .Z(Z), .W(W), .D(d_ok));

   dec_4x16_with_fault4 #(.FAULT_VAL(1)) u_s1 (
      .clk(clk), .rst(rst), .X(X), .Y(Y), .Z(Z), .W(W), .D(d_s1));

   // cfg 0: line 4 stuck-at-0, cfg 1: no fault, cfg 2: line 4 stuck-at-1
   function automatic logic [15:0] ref_d(int cfg, int n);
      logic [15:0] v;
      v = 16'h0000;
      for (int i = 0; i < 16; i++) if (i == n) v[i] = 1'b1;
      if (cfg == 0) v[4] = 1'b0;
      if (cfg == 2) v[4] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_sel(input int n);
      {X, Y, Z, W} = n[3:0];
   endtask

   task automatic step(input int n);
      @(negedge clk);
      set_sel(n);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input int n);
      chk({tag, "_def"}, d_def, ref_d(0, n));
      chk({tag, "_ok"},  d_ok,  ref_d(1, n));
      chk({tag, "_s1"},  d_s1,  ref_d(2, n));
   endtask

   initial begin
      int n;
      // reset holds D at zero across an edge
      set_sel(0);
      @(posedge clk);
      #1;
      chk("rst_def", d_def, 16'h0000);
      chk("rst_ok",  d_ok,  16'h0000);
      chk("rst_s1",  d_s1,  16'h0000);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rel_def", d_def, 16'h0001);
      chk("rel_ok",  d_ok,  16'h0001);
      chk("rel_s1",  d_s1,  16'h0011);

      // full sweep, one select per cycle
      for (int i = 0; i < 16; i++) begin
         step(i);
         chk_all($sformatf("sweep%0d", i), i);
         chk("onehot_ok", {15'd0, $onehot(d_ok)}, 16'h0001);
      end

      // directed boundary values
      step(4);
      chk("n4_def", d_def, 16'h0000);
      chk("n4_ok",  d_ok,  16'h0010);
      chk("n4_s1",  d_s1,  16'h0010);
      step(9);
      chk("n9_s1",  d_s1,  16'h0210);
      step(7);
      chk("n7_def", d_def, 16'h0080);
      step(8);
      chk("n8_def", d_def, 16'h0100);

      // randomized selects
      for (int i = 0; i < 60; i++) begin
         n = int'($urandom_range(15, 0));
         step(n);
         chk_all($sformatf("rnd%0d", i), n);
      end

      // mid-cycle reset while n=13 is applied
      step(2);
      @(negedge clk);
      set_sel(13);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_def", d_def, 16'h0000);
      chk("mid_ok",  d_ok,  16'h0000);
      chk("mid_s1",  d_s1,  16'h0000);
      @(posedge clk);
      #1;
      chk("midhold_def", d_def, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("midrel_def", d_def, 16'h2000);
      chk("midrel_ok",  d_ok,  16'h2000);
      chk("midrel_s1",  d_s1,  16'h2010);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no completion expected finish");
      $fatal(1, "timeout");
   end
endmodule
